// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider.
// Each channel produces a 50%-duty divided clock with a tick strobe on every
// rising edge, runtime divisor updates applied at period boundaries, and
// glitch-free enable/disable (a started high phase always completes).
// Optional feature: define PHASE_SYNC_EN to add the i_sync input, which
// restarts every channel low on the same edge so they realign in phase.
module clock_divider_bank #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          i_ch_en,
   input  logic                       i_wr_en,
   input  logic [$clog2(NUM_CH)-1:0]  i_wr_ch,
   input  logic [CNT_W-1:0]           i_wr_div,
`ifdef PHASE_SYNC_EN
   input  logic                       i_sync,
`endif
   output logic [NUM_CH-1:0]          o_clk_out,
   output logic [NUM_CH-1:0]          o_tick,
   output logic [NUM_CH-1:0]          o_pend,
   output logic                       o_wr_err
);

   localparam int              CH_W    = $clog2(NUM_CH);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0]  r_cnt      [NUM_CH];
   logic [CNT_W-1:0]  r_div_act  [NUM_CH];
   logic [CNT_W-1:0]  r_div_pend [NUM_CH];
   logic [NUM_CH-1:0] r_clk_out;
   logic [NUM_CH-1:0] r_tick;
   logic [NUM_CH-1:0] r_pend;
   logic              r_wr_err;

   logic [NUM_CH-1:0] w_run;
   logic [NUM_CH-1:0] w_last;
   logic              w_wr_ok;
   logic              w_wr_bad;
   logic              w_sync;

   // The phase-sync request collapses to a constant 0 when the feature is absent,
   // so the channel logic below is identical in both builds.
`ifdef PHASE_SYNC_EN
   always_comb begin
      w_sync = i_sync;
   end
`else
   always_comb begin
      w_sync = 1'b0;
   end
`endif

   // A channel keeps running while enabled or while a high phase is still in
   // progress; w_last marks the final cycle of the current half period.
   always_comb begin
      w_run  = '0;
      w_last = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         w_run[ch]  = i_ch_en[ch] | r_clk_out[ch];
         w_last[ch] = (r_cnt[ch] == (r_div_act[ch] - 1'b1));
      end
   end

   // Writes are accepted only for an existing channel and a nonzero divisor;
   // anything else is flagged and otherwise ignored.
   always_comb begin
      w_wr_ok  = i_wr_en && (int'(i_wr_ch) < NUM_CH) && (i_wr_div != '0);
      w_wr_bad = i_wr_en && !w_wr_ok;
   end

   // Per-channel counters, divided clocks, tick strobes and divisor hand-over.
   // The write is evaluated last so a write coinciding with a boundary stays
   // pending while the boundary consumes the previously stored divisor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_out <= '0;
         r_tick    <= '0;
         r_pend    <= '0;
         r_wr_err  <= 1'b0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_cnt[ch]      <= '0;
            r_div_act[ch]  <= DIV_RST;
            r_div_pend[ch] <= DIV_RST;
         end
      end else begin
         r_wr_err <= w_wr_bad;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_sync || !w_run[ch]) begin
               r_cnt[ch]     <= '0;
               r_clk_out[ch] <= 1'b0;
               r_tick[ch]    <= 1'b0;
               if (r_pend[ch]) begin
                  r_div_act[ch] <= r_div_pend[ch];
                  r_pend[ch]    <= 1'b0;
               end
            end else if (w_last[ch]) begin
               r_cnt[ch]     <= '0;
               r_clk_out[ch] <= ~r_clk_out[ch];
               r_tick[ch]    <= ~r_clk_out[ch];
               if (r_clk_out[ch] && r_pend[ch]) begin
                  r_div_act[ch] <= r_div_pend[ch];
                  r_pend[ch]    <= 1'b0;
               end
            end else begin
               r_cnt[ch]  <= r_cnt[ch] + 1'b1;
               r_tick[ch] <= 1'b0;
            end
            if (w_wr_ok && (i_wr_ch == CH_W'(ch))) begin
               r_div_pend[ch] <= i_wr_div;
               r_pend[ch]     <= 1'b1;
            end
         end
      end
   end

   // All outputs come straight from registers.
   always_comb begin
      o_clk_out = r_clk_out;
      o_tick    = r_tick;
      o_pend    = r_pend;
      o_wr_err  = r_wr_err;
   end

endmodule
